// File: rtl/cache_pkg.sv
// Shared constants and types for the cache/memory arbiter: line geometry, FSM states, owners.
// Pure declarations; no timing or flow control of its own.
package cache_pkg;

    localparam int LINE_WORDS = 16;
    localparam int IDX_W      = $clog2(LINE_WORDS);
    localparam int OFFSET_W   = IDX_W + 2;
    localparam int BEAT_W     = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/line_beat_ctr.sv
// Counts data beats of one line, saturating at LINE_WORDS; 1-cycle registered count.
// Flags beats arriving after the line is complete and whether this cycle completes it exactly.
module line_beat_ctr
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             tc_o,
    output logic             ovf_o,
    output logic             full_next_o
);

    logic [BEAT_W-1:0] beat_q, beat_d;

    assign tc_o  = (beat_q == BEAT_W'(LINE_WORDS));
    assign ovf_o = inc_i && tc_o;
    assign idx_o = beat_q[IDX_W-1:0];

    always_comb begin
        beat_d = beat_q;
        if (clr_i) begin
            beat_d = '0;
        end else if (inc_i && !tc_o) begin
            beat_d = beat_q + 1'b1;
        end
    end

    // An overflowing beat leaves the count saturated, but the line is not "exactly full".
    assign full_next_o = (beat_d == BEAT_W'(LINE_WORDS)) && !ovf_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/cache_mem_arb.sv
// Arbitrates I/D cache line requests onto the memory controller and sequences the 16-beat transfer.
// Grant 1 cycle after request; read beats forwarded combinationally; writes advance only on mem_wr_rdy.
module cache_mem_arb
    import cache_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wb_data,
    output logic             i_gnt,
    output logic             d_gnt,
    output logic             i_done,
    output logic             d_done,
    output logic             fill_vld_i,
    output logic             fill_vld_d,
    output logic [IDX_W-1:0] fill_idx,
    output logic [31:0]      fill_data,
    output logic [IDX_W-1:0] wb_idx,
    output logic             xfer_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    input  logic             mem_ready,
    output logic [31:0]      mem_wdata,
    input  logic             mem_wr_rdy,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_rd_vld,
    input  logic             tx_done
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_t          state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                err_q, err_d;
    logic                i_gnt_q, i_gnt_d;
    logic                d_gnt_q, d_gnt_d;

    logic             pick_i;
    logic             in_xfer;
    logic             rd_beat;
    logic             wr_beat;
    logic             beat_clr;
    logic [IDX_W-1:0] beat_idx;
    logic             beat_tc;
    logic             beat_ovf;
    logic             beat_full_next;
    logic             fwd;
    logic             wb_active;

    assign pick_i   = i_req && (!d_req || (starve_q == STARVE_W'(STARVE_MAX)));
    assign in_xfer  = (state_q == XFER);
    assign rd_beat  = in_xfer && !we_q && mem_rd_vld;
    assign wr_beat  = in_xfer && we_q && mem_wr_rdy;
    assign beat_clr = (state_q == ISSUE) && mem_ready;

    line_beat_ctr u_beat_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (beat_clr),
        .inc_i       (rd_beat || wr_beat),
        .idx_o       (beat_idx),
        .tc_o        (beat_tc),
        .ovf_o       (beat_ovf),
        .full_next_o (beat_full_next)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        starve_d = starve_q;
        err_d    = err_q;
        i_gnt_d  = 1'b0;
        d_gnt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_req) begin
                    starve_d = '0;
                end
                if (i_req || d_req) begin
                    state_d = ISSUE;
                    if (pick_i) begin
                        owner_d  = OWN_I;
                        we_d     = 1'b0;
                        addr_d   = line_align(i_addr);
                        i_gnt_d  = 1'b1;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_D;
                        we_d    = d_we;
                        addr_d  = line_align(d_addr);
                        d_gnt_d = 1'b1;
                        if (i_req && (starve_q != STARVE_W'(STARVE_MAX))) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (beat_ovf) begin
                    err_d = 1'b1;
                end
                // A beat arriving with tx_done is already included in beat_full_next.
                if (tx_done) begin
                    if (!beat_full_next) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_I;
            we_q     <= 1'b0;
            addr_q   <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
            i_gnt_q  <= 1'b0;
            d_gnt_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            starve_q <= starve_d;
            err_q    <= err_d;
            i_gnt_q  <= i_gnt_d;
            d_gnt_q  <= d_gnt_d;
        end
    end

    assign fwd       = rd_beat && !beat_tc;
    assign wb_active = in_xfer && we_q;

    assign i_gnt      = i_gnt_q;
    assign d_gnt      = d_gnt_q;
    assign i_done     = (state_q == DONE) && (owner_q == OWN_I);
    assign d_done     = (state_q == DONE) && (owner_q == OWN_D);
    assign fill_vld_i = fwd && (owner_q == OWN_I);
    assign fill_vld_d = fwd && (owner_q == OWN_D);
    assign fill_idx   = fwd ? beat_idx : '0;
    assign fill_data  = fwd ? mem_rdata : '0;
    assign wb_idx     = wb_active ? beat_idx : '0;
    assign mem_wdata  = wb_active ? d_wb_data : '0;
    assign xfer_err   = err_q;
    assign mem_req    = (state_q == ISSUE);
    assign mem_we     = mem_req && we_q;
    assign mem_addr   = mem_req ? addr_q : '0;

endmodule

// File: doc/cache_mem_arb.md
# cache_mem_arb

Arbiter and transfer sequencer between the instruction cache, the data cache and the shared memory controller. It accepts line-fill requests from the I-cache and fill/writeback requests from the D-cache, and grants one of them. It issues a line-aligned transaction to the memory controller and counts the 16 data beats. It routes read beats to the winner and write beats from the D-cache, and signals completion. D-side requests have priority; a starvation counter guarantees I-side forward progress.

## Interface
- LINE_WORDS, 16, 32-bit words per cache line (power of two)
- STARVE_MAX, 4, consecutive D grants with I pending before I wins
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  I-cache line-fill request, held until i_done
- i_addr  in  32  I-cache miss address
- d_req  in  1  D-cache request, held until d_done
- d_we  in  1  1 = writeback of dirty line, 0 = fill
- d_addr  in  32  D-cache line address
- d_wb_data  in  32  writeback word selected by wb_idx (combinational from D-cache)
- i_gnt / d_gnt  out  1  one-cycle grant pulse
- i_done / d_done  out  1  one-cycle completion pulse
- fill_vld_i / fill_vld_d  out  1  fill beat valid for I / D
- fill_idx  out  4  word index of current fill beat
- fill_data  out  32  fill beat data
- wb_idx  out  4  word index requested from D-cache during writeback
- xfer_err  out  1  sticky; beat-count violation, cleared only by reset
- mem_req  out  1  transaction request to memory controller
- mem_we  out  1  transaction is a write
- mem_addr  out  32  line-aligned address, low log2(LINE_WORDS)+2 bits zero
- mem_ready  in  1  memory controller accepts mem_req
- mem_wdata  out  32  write beat data
- mem_wr_rdy  in  1  memory consumes write beat this cycle
- mem_rdata  in  32  read beat data
- mem_rd_vld  in  1  read beat valid
- tx_done  in  1  memory controller transaction complete

## Operation
- FSM states: IDLE, ISSUE, XFER, DONE.
- IDLE: if any request is pending, pick the owner, latch owner, op and line-aligned address, pulse the owner's gnt, and go to ISSUE.
- Arbitration: D wins, except when starve_cnt == STARVE_MAX and i_req is high.
- starve_cnt increments (saturating) on each D grant while i_req is high. It clears on an I grant or when i_req is low in IDLE.
- ISSUE: mem_req=1, mem_we=op, mem_addr=latched address. On mem_ready, go to XFER with beat=0.
- XFER, read: each mem_rd_vld drives fill_vld_<owner>=1, fill_data=mem_rdata and fill_idx=beat in the same cycle (combinational), then beat increments.
- XFER, write: wb_idx=beat and mem_wdata=d_wb_data. beat increments on mem_wr_rdy.
- XFER -> DONE on tx_done.
- DONE: pulse <owner>_done for one cycle, then go to IDLE.
- Beats after LINE_WORDS have been counted are not forwarded (fill_vld stays 0) and set xfer_err.
- tx_done with beat != LINE_WORDS sets xfer_err; the transaction still completes normally through DONE.
- Requests dropped mid-transaction are ignored; the transaction is committed once granted. The address is latched at grant.
- I requests never write; the requester decides the D-side writeback-then-fill order.

## Timing
- Reset: state=IDLE, starve_cnt=0, beat=0, xfer_err=0. All outputs are 0.
- Grant latency: request seen in IDLE -> gnt pulse and mem_req both in the next cycle (ISSUE entry).
- Minimum transaction: 1 IDLE + 1+ ISSUE + 16+ XFER + 1 DONE cycles.
- mem_req stays high throughout ISSUE and drops in the cycle after mem_ready.
- tx_done is only sampled in XFER and is ignored in other states. A beat and tx_done in the same cycle: the beat is counted first.
- The requester must deassert req in the cycle after done. IDLE re-arbitrates one cycle after DONE, so back-to-back grants are 2 cycles apart at minimum.
- Async reset mid-transaction: immediate return to IDLE, no done pulse, and outstanding memory activity is abandoned.

## Structure
- Shared package cache_pkg holds LINE_WORDS, OFFSET_W = log2(LINE_WORDS)+2, the arb_state_t enum (IDLE, ISSUE, XFER, DONE), and the owner_t enum (OWN_I, OWN_D).
- One natural sub-module: line_beat_ctr (beat counter with terminal-count and overflow flags). The FSM, arbitration and starve counter live in cache_mem_arb.

## Test plan
- I-only fill at i_addr=0x0000_1234 -> i_gnt pulse, mem_addr=0x0000_1200, mem_we=0. 16 beats with mem_rdata=0xA0..0xAF give fill_idx 0..15 with matching data, then i_done; xfer_err=0.
- Simultaneous i_req and d_req (fill) in IDLE -> d_gnt first, d_done, then i_gnt within 2 cycles of d_done.
- d_req held continuously with i_req pending -> after 4 D grants the 5th grant goes to I; starve_cnt then reads 0.
- D writeback, d_addr=0x8000_0040 -> mem_we=1, wb_idx steps 0..15 only on mem_wr_rdy cycles (insert stalls), mem_wdata tracks d_wb_data, then d_done.
- tx_done after 10 beats -> xfer_err=1 and done pulse. A 17th read beat in a separate transaction -> not forwarded, xfer_err=1.
- rst_n asserted mid-XFER at beat 7 -> all outputs 0 immediately, no done pulse. The next request is granted normally after reset release.
